// File: rtl/alu_pkg.sv
// Shared types and command decode helpers for the bit-serial ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      CMD_ADD  = 3'd0,
      CMD_SUB  = 3'd1,
      CMD_XOR  = 3'd2,
      CMD_SLT  = 3'd3,
      CMD_AND  = 3'd4,
      CMD_NAND = 3'd5,
      CMD_NOR  = 3'd6,
      CMD_OR   = 3'd7
   } alu_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Subtract-style commands add ~b with a carry-in of 1.
   function automatic logic cmd_inverts_b(input alu_cmd_e cmd);
      return (cmd == CMD_SUB) || (cmd == CMD_SLT);
   endfunction

   // Commands whose carry/overflow flags are meaningful.
   function automatic logic cmd_is_arith(input alu_cmd_e cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SLT);
   endfunction

endpackage

// File: rtl/alu_bit_cell.sv
// One-bit combinational ALU slice: full adder plus bitwise logic select.
module alu_bit_cell
   import alu_pkg::*;
(
   input  logic     a_i,
   input  logic     b_i,
   input  logic     cin_i,
   input  logic     invtb_i,
   input  alu_cmd_e command_i,
   output logic     bit_o,
   output logic     sum_o,
   output logic     cout_o
);

   logic b1;

   assign b1     = b_i ^ invtb_i;
   assign sum_o  = a_i ^ b1 ^ cin_i;
   assign cout_o = (a_i & b1) | (cin_i & (a_i ^ b1));

   // Result bit selection; logic ops see the uninverted b.
   always_comb begin
      bit_o = sum_o;
      case (command_i)
         CMD_XOR:  bit_o = a_i ^ b_i;
         CMD_AND:  bit_o = a_i & b_i;
         CMD_NAND: bit_o = ~(a_i & b_i);
         CMD_NOR:  bit_o = ~(a_i | b_i);
         CMD_OR:   bit_o = a_i | b_i;
         default:  bit_o = sum_o;
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: one operand bit per clock, LSB first, valid/ready on both sides.
module alu_serial
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       command_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carryout_o,
   output logic             overflow_o,
   output logic             zero_o
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   alu_cmd_e         cmd_q, cmd_d;
   logic             carry_q, carry_d, zacc_q, zacc_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

   logic cell_bit, cell_sum, cell_cout, slt_bit;

   alu_bit_cell u_cell (
      .a_i       (a_q[0]),
      .b_i       (b_q[0]),
      .cin_i     (carry_q),
      .invtb_i   (cmd_inverts_b(cmd_q)),
      .command_i (cmd_q),
      .bit_o     (cell_bit),
      .sum_o     (cell_sum),
      .cout_o    (cell_cout)
   );

   // Sign of a-b corrected by overflow, valid on the MSB step.
   assign slt_bit = cell_sum ^ (carry_q ^ cell_cout);

   // Next-state, datapath step and final flag computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      cmd_d       = cmd_q;
      carry_d     = carry_q;
      zacc_d      = zacc_q;
      res_d       = res_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               state_d = ST_RUN;
               a_d     = a_i;
               b_d     = b_i;
               cmd_d   = alu_cmd_e'(command_i);
               carry_d = cmd_inverts_b(alu_cmd_e'(command_i));
               zacc_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = cell_cout;
            zacc_d  = zacc_q | cell_bit;
            res_d   = {cell_bit, res_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               cout_d  = cmd_is_arith(cmd_q) & cell_cout;
               ovf_d   = cmd_is_arith(cmd_q) & (carry_q ^ cell_cout);
               if (cmd_q == CMD_SLT) begin
                  res_d  = WIDTH'(slt_bit);
                  zero_d = ~slt_bit;
               end else begin
                  zero_d = ~(zacc_q | cell_bit);
               end
            end
         end
         ST_DONE: begin
            if (out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cmd_q       <= CMD_ADD;
         carry_q     <= 1'b0;
         zacc_q      <= 1'b0;
         res_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cmd_q       <= cmd_d;
         carry_q     <= carry_d;
         zacc_q      <= zacc_d;
         res_q       <= res_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = res_q;
   assign carryout_o  = cout_q;
   assign overflow_o  = ovf_q;
   assign zero_o      = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial with directed vectors.
module tb_alu_serial;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   command = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         carryout, overflow, zero;

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic         c;
      logic         o;
      logic         z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   alu_serial #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .command_i   (command),
      .a_i         (a),
      .b_i         (b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .carryout_o  (carryout),
      .overflow_o  (overflow),
      .zero_o      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every consumed response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_response actual=%h required=none", result);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_result"}, 64'(result), 64'(e.res));
               chk({e.name, "_flags"}, 64'({carryout, overflow, zero}), 64'({e.c, e.o, e.z}));
            end
         end
      end
   end

   // Drive one request; caller is 1 time unit after a rising edge.
   task automatic send(input alu_cmd_e c, input logic [W-1:0] av, input logic [W-1:0] bv);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'(1));
      command  = c;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic issue(input string name, input alu_cmd_e c, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] r,
                        input logic co, input logic ov, input logic z);
      exp_t e;
      e.name = name; e.res = r; e.c = co; e.o = ov; e.z = z;
      sb.push_back(e);
      send(c, av, bv);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'(0));
         sb.delete();
      end
   endtask

   initial begin
      int n;
      int extra;
      #12;
      chk("reset_state", 64'({in_ready, out_valid, result, carryout, overflow, zero}),
          64'({1'b1, 1'b0, 32'h0, 3'b000}));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First request also measures latency (edges counted from the accept edge inclusive).
      issue("add_ovf", CMD_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency_edges", 64'(n), 64'(33));
      wait_drain();

      issue("sub_eq",   CMD_SUB,  32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1'b1);
      wait_drain();
      issue("sub_neg",  CMD_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      wait_drain();
      issue("slt_true", CMD_SLT,  32'h8000_0000, 32'h1,         32'h1,         1'b1, 1'b1, 1'b0);
      wait_drain();
      issue("slt_false",CMD_SLT,  32'h1,         32'h8000_0000, 32'h0,         1'b0, 1'b1, 1'b1);
      wait_drain();
      issue("and",  CMD_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
      wait_drain();
      issue("nand", CMD_NAND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
      wait_drain();
      issue("nor",  CMD_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
      wait_drain();
      issue("or",   CMD_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
      wait_drain();
      issue("xor",  CMD_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
      wait_drain();

      // Backpressure with an ignored request pulse in the window.
      out_ready = 1'b0;
      issue("add_wrap", CMD_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("hold_stable", 64'({result, carryout, overflow, zero, out_valid, in_ready}),
             64'({32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}));
         if (i == 3) begin
            command = CMD_XOR; a = 32'h1234_5678; b = 32'h1; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_ready", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
      chk("release_drained", 64'(sb.size()), 64'(0));
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) extra++;
         @(posedge clk); #1;
      end
      chk("no_queued_request", 64'(extra), 64'(0));

      // Async reset while processing bit 17.
      send(CMD_ADD, 32'h1234_5678, 32'h1);
      repeat (17) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 64'({in_ready, out_valid, result, carryout, overflow, zero}),
          64'({1'b1, 1'b0, 32'h0, 3'b000}));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue("add_after_rst", CMD_ADD, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 1'b0);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
